// File: rtl/seq_rr_sched.sv
// Round-robin scheduler that time-shares one 10101 Mealy detector among NCH serial requesters.
// Define SEQ_OVERLAP_EN to let a match continue from "101", so overlapping matches count.
module seq_rr_sched #(
  parameter int NCH  = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  xbit,
  output logic [NCH-1:0]  grant,
  output logic            hit,
  output logic [1:0]      hit_id,
  input  logic            clr,
  input  logic [1:0]      cnt_sel,
  output logic [CNTW-1:0] cnt_out
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  logic [1:0]      ptr_q, ptr_d;
  logic [2:0]      st_q  [NCH];
  logic [2:0]      st_d  [NCH];
  logic [CNTW-1:0] cnt_q [NCH];
  logic [CNTW-1:0] cnt_d [NCH];
  logic            hit_q, hit_d;
  logic [1:0]      hit_id_q, hit_id_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       consume;
  logic       match;
  logic [2:0] nxt;

  // Returns {match, next_state}; encodings 5-7 fall back to idle.
  function automatic logic [3:0] step(input logic [2:0] s, input logic b);
    logic       m;
    logic [2:0] ns;
    m  = 1'b0;
    ns = S0;
    case (s)
      S0: ns = b ? S1 : S0;
      S1: ns = b ? S1 : S2;
      S2: ns = b ? S3 : S0;
      S3: ns = b ? S1 : S4;
      S4: begin
        if (b) begin
          m = 1'b1;
`ifdef SEQ_OVERLAP_EN
          ns = S3;
`else
          ns = S0;
`endif
        end else begin
          ns = S0;
        end
      end
      default: ns = S0;
    endcase
    return {m, ns};
  endfunction

  // Search ptr+1 .. ptr+NCH; the 2-bit add wraps so the last candidate is ptr itself.
  always_comb begin
    grant = '0;
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && !clr && !rst) grant[win] = 1'b1;
  end

  assign consume = |grant;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    hit_d    = 1'b0;
    hit_id_d = hit_id_q;
    {match, nxt} = step(st_q[win], xbit[win]);
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        st_d[i]  = S0;
        cnt_d[i] = '0;
      end
      ptr_d = 2'(NCH - 1);
    end else if (consume) begin
      st_d[win] = nxt;
      ptr_d     = win;
      if (match) begin
        hit_d    = 1'b1;
        hit_id_d = win;
        if (cnt_q[win] != '1) cnt_d[win] = cnt_q[win] + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= 2'(NCH - 1);
      hit_q    <= 1'b0;
      hit_id_q <= 2'd0;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= S0;
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      hit_q    <= hit_d;
      hit_id_q <= hit_id_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hit     = hit_q;
  assign hit_id  = hit_id_q;
  assign cnt_out = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq_rr_sched.sv
// Directed bench for seq_rr_sched: a CNTW=8 instance for the main flows, a CNTW=2 one for saturation.
module tb_seq_rr_sched;

`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req, xbit, grant;
  logic       hit;
  logic [1:0] hit_id;
  logic       clr;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_out;

  logic [3:0] s_req, s_xbit, s_grant;
  logic       s_hit;
  logic [1:0] s_hit_id;
  logic       s_clr;
  logic [1:0] s_cnt_sel;
  logic [1:0] s_cnt_out;

  int checks = 0;
  int errors = 0;

  seq_rr_sched #(.NCH(4), .CNTW(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .xbit(xbit), .grant(grant),
    .hit(hit), .hit_id(hit_id), .clr(clr), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  seq_rr_sched #(.NCH(4), .CNTW(2)) u_sat (
    .clk(clk), .rst(rst), .req(s_req), .xbit(s_xbit), .grant(s_grant),
    .hit(s_hit), .hit_id(s_hit_id), .clr(s_clr), .cnt_sel(s_cnt_sel), .cnt_out(s_cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one bit on a single channel, check its grant, then check the hit pulse after the edge.
  task automatic send(input int ch, input logic b, input logic exp_hit, input string tag);
    req      = 4'b0;
    req[ch]  = 1'b1;
    xbit     = 4'b0;
    xbit[ch] = b;
    #1;
    chk({tag, "_grant"}, 32'(grant), 32'd1 << ch);
    cyc();
    req  = 4'b0;
    xbit = 4'b0;
    chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    if (exp_hit) chk({tag, "_id"}, 32'(hit_id), 32'(ch));
  endtask

  task automatic sel(input logic [1:0] s, input int exp, input string tag);
    cnt_sel = s;
    #1;
    chk(tag, 32'(cnt_out), 32'(exp));
  endtask

  initial begin
    logic [6:0] p1;
    logic [4:0] p3;
    logic [6:0] p4;
    int nhits;
    int k;

    p1 = 7'b1010101;
    p3 = 5'b10101;
    p4 = 7'b1010100;

    rst = 1'b1; req = 4'hF; xbit = 4'h0; clr = 1'b0; cnt_sel = 2'd0;
    s_req = 4'h0; s_xbit = 4'h0; s_clr = 1'b0; s_cnt_sel = 2'd3;
    #12;
    chk("rst_grant",  32'(grant),   32'd0);
    chk("rst_hit",    32'(hit),     32'd0);
    chk("rst_hit_id", 32'(hit_id),  32'd0);
    chk("rst_cnt",    32'(cnt_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'h0;

    // ch0 alone: 1010101
    for (int i = 0; i < 7; i++) begin
      send(0, p1[6-i], (i == 4) || (OVL && i == 6), "t1_bit");
      if (i == 4) chk("t1_cnt_at_hit", 32'(cnt_out), 32'd1);
    end
    chk("t1_cnt_final", 32'(cnt_out), OVL ? 32'd2 : 32'd1);

    clr = 1'b1; req = 4'hF;
    #1;
    chk("clr_grant", 32'(grant), 32'd0);
    cyc();
    clr = 1'b0; req = 4'h0;
    chk("clr_cnt0", 32'(cnt_out), 32'd0);

    // Rotation with all four requesting
    req = 4'hF; xbit = 4'h0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t2_grant", 32'(grant), 32'd1 << (c % 4));
      cyc();
    end

    // ch1 sends 10101 while the others send zeros
    nhits = 0;
    for (int c = 0; c < 20; c++) begin
      k = (c + 2) / 4;
      req  = 4'hF;
      xbit = 4'h0;
      xbit[1] = (k < 5) ? p3[4-k] : 1'b0;
      #1;
      chk("t3_grant", 32'(grant), 32'd1 << (c % 4));
      cyc();
      if (hit === 1'b1) nhits++;
      chk("t3_hit", 32'(hit), 32'(c == 17));
      if (c == 17) chk("t3_hit_id", 32'(hit_id), 32'd1);
    end
    req = 4'h0; xbit = 4'h0;
    chk("t3_nhits", 32'(nhits), 32'd1);
    sel(2'd0, 0, "t3_cnt0");
    sel(2'd1, 1, "t3_cnt1");
    sel(2'd2, 0, "t3_cnt2");
    sel(2'd3, 0, "t3_cnt3");

    // Saturation on the 2-bit counter instance, ch3 alone
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 7; i++) begin
        s_req = 4'b1000;
        s_xbit = 4'b0000;
        s_xbit[3] = p4[6-i];
        cyc();
        if (i == 4) begin
          chk("t4_hit", 32'(s_hit), 32'd1);
          chk("t4_cnt", 32'(s_cnt_out), (r < 3) ? 32'(r + 1) : 32'd3);
        end
      end
    end
    s_req = 4'h0; s_xbit = 4'h0;

    // clr discards a pending bit and wipes ch2's partial match
    send(2, 1'b1, 1'b0, "t5_pre");
    send(2, 1'b0, 1'b0, "t5_pre");
    send(2, 1'b1, 1'b0, "t5_pre");
    send(2, 1'b0, 1'b0, "t5_pre");
    clr = 1'b1; req = 4'b0100; xbit = 4'b0100;
    #1;
    chk("t5_clr_grant", 32'(grant), 32'd0);
    cyc();
    clr = 1'b0; req = 4'h0; xbit = 4'h0;
    chk("t5_clr_hit", 32'(hit), 32'd0);
    sel(2'd0, 0, "t5_cnt0");
    sel(2'd1, 0, "t5_cnt1");
    sel(2'd2, 0, "t5_cnt2");
    sel(2'd3, 0, "t5_cnt3");
    send(2, 1'b1, 1'b0, "t5_post");
    send(2, 1'b0, 1'b0, "t5_s1");
    send(2, 1'b1, 1'b0, "t5_s1");
    send(2, 1'b0, 1'b0, "t5_s1");
    send(2, 1'b1, 1'b1, "t5_s1");
    sel(2'd2, 1, "t5_cnt2_after");

    // Asynchronous reset while a hit is showing and ch0 sits in S4
    send(1, 1'b1, 1'b0, "t6_pre");
    send(1, 1'b0, 1'b0, "t6_pre");
    send(1, 1'b1, 1'b0, "t6_pre");
    send(1, 1'b0, 1'b0, "t6_pre");
    send(0, 1'b1, 1'b0, "t6_pre");
    send(0, 1'b0, 1'b0, "t6_pre");
    send(0, 1'b1, 1'b0, "t6_pre");
    send(0, 1'b0, 1'b0, "t6_pre");
    send(1, 1'b1, 1'b1, "t6_hit");
    sel(2'd1, 1, "t6_cnt1_pre");
    req = 4'b0001; xbit = 4'b0001;
    #1;
    chk("t6_grant_pre", 32'(grant), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_hit",   32'(hit),     32'd0);
    chk("t6_rst_grant", 32'(grant),   32'd0);
    chk("t6_rst_id",    32'(hit_id),  32'd0);
    chk("t6_rst_cnt1",  32'(cnt_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'hF; xbit = 4'hF;
    #1;
    chk("t6_first_grant", 32'(grant), 32'd1);
    cyc();
    req = 4'h0; xbit = 4'h0;
    chk("t6_post_hit", 32'(hit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_rr_sched.md
# seq_rr_sched

Round-robin scheduler that time-shares one 10101 Mealy detector datapath among NCH serial requesters. Each requester offers one bit per handshake. The block grants one requester per cycle and advances that channel's private detector state. It reports matches tagged with the channel id and keeps a saturating per-channel hit counter. It sits between the serial front-ends and the status/readback logic.

## Interface
- NCH, 4, number of requesters; only 4 is supported; sets the width of req/xbit/grant, and hit_id/cnt_sel are 2 bits.
- CNTW, 8, width of each per-channel hit counter.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NCH  per-channel request; bit offered this cycle is valid.
- xbit  in  NCH  per-channel serial data bit, paired with req.
- grant  out  NCH  one-hot grant, combinational from req and the pointer.
- hit  out  1  registered one-cycle pulse; a 10101 match completed.
- hit_id  out  2  channel of the current hit; holds its last value while hit=0.
- clr  in  1  synchronous clear of states, counters and the pointer.
- cnt_sel  in  2  counter readback select.
- cnt_out  out  CNTW  hit counter of channel cnt_sel, combinational mux.

## Operation
- Handshake: a bit is consumed at the rising edge where req[i] & grant[i]. The requester holds req[i] and xbit[i] stable until consumed. A requester may drop req at any time without penalty.
- Arbitration: the last-granted pointer is ptr (2 bits).
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); the first asserted req wins.
  - ptr updates to the winner on consumption; it is unchanged when no req is asserted.
  - grant=0 when req=0, when clr=1, or while rst=1.
- Per-channel detector state is 3 bits: S0 idle, S1 "1", S2 "10", S3 "101", S4 "1010". Only the granted channel's state changes.
  - S0: 1→S1, 0→S0
  - S1: 1→S1, 0→S2
  - S2: 1→S3, 0→S0
  - S3: 1→S1, 0→S4
  - S4: 0→S0; 1→match, next state per Configuration.
- Match: hit=1 and hit_id=the granted channel in the cycle after consumption. The channel counter increments, saturating at 2^CNTW−1.
- clr=1 at an edge:
  - all states → S0, all counters → 0, ptr → NCH−1, hit → 0.
  - clr has priority over a simultaneous consumption; that bit is discarded and not acknowledged.
- Unused state encodings 5–7 go to S0 on the next consumption for that channel.

## Timing
- Reset values: hit=0, hit_id=0, all counters 0, all states S0, ptr=NCH−1 (channel 0 wins first), grant=0, cnt_out=0.
- rst is asynchronous: assertion mid-cycle immediately clears all registers. A bit offered in that cycle is lost.
- Throughput: one bit per cycle in total, shared across channels. With k channels requesting continuously, each channel gets one grant every k cycles.
- Latency: 1 cycle from the consuming edge to the hit pulse. The counter value is visible on cnt_out in the same cycle as hit.
- Back-to-back hits from different channels on consecutive cycles are legal; hit stays high and hit_id changes each cycle.

## Configuration
- SEQ_OVERLAP_EN defined: S4 on 1 → S3, so overlapping matches count. Example: 1010101 gives 2 hits.
- SEQ_OVERLAP_EN undefined: S4 on 1 → S0, non-overlapping only. Example: 1010101 gives 1 hit. A match needs 5 fresh bits after the previous one.

## Test plan
- req=0001, ch0 bits 1,0,1,0,1,0,1 on consecutive cycles → with SEQ_OVERLAP_EN: hit/hit_id=0 after bits 5 and 7, cnt_out(sel 0)=2. Without it: a single hit after bit 5, count 1.
- req=1111 held 8 cycles → grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- req=1111; ch1 sends 1,0,1,0,1 while ch0, ch2 and ch3 send 0 → exactly one hit, hit_id=1, one cycle after ch1's 5th grant (cycle 18). Counters of ch0, ch2 and ch3 remain 0.
- CNTW=2, ch3 alone, 5 separate 10101 patterns → cnt_out(sel 3) reads 1,2,3,3,3.
- ch2 sends 1,0,1,0; clr pulses with req2 high → no grant that cycle, all counters read 0. A following 1 on ch2 gives no hit, and ch2's state is S1.
- rst asserted mid-cycle after ch0 has received 1,0,1,0 → hit and grant go 0 immediately. After release, a single 1 on ch0 gives no hit, and channel 0 wins first.
